// File: rtl/sync_fifo_pkg.sv
// Shared helpers and mode constants for the parametrised synchronous FIFO family.
// Pointer/address width convention: AW = clog2(DEPTH); pointers and count are AW+1 bits.
package sync_fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    for (v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky error
// flags and a selectable standard (registered) or first-word-fall-through read port.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AF_LEVEL = 28,
  parameter int unsigned AE_LEVEL = 4,
  parameter int unsigned FWFT     = FIFO_STD,
  localparam int unsigned AW      = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] ram_rdata;

  // Status flags decode the registered count directly.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH[AW:0]);
  assign almost_full  = (count_q >= AF_LEVEL[AW:0]);
  assign almost_empty = (count_q <= AE_LEVEL[AW:0]);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    rd_acc   = rd & ~empty;
    // A pop in the same cycle frees a slot, so a write at full still lands.
    wr_acc   = wr & (~full | rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    count_d     = wr_ptr_d - rd_ptr_d;
    // A fresh error event wins over a simultaneous clear.
    overflow_d  = (overflow_q & ~clr_err) | (wr & full & ~rd_acc);
    underflow_d = (underflow_q & ~clr_err) | (rd & empty);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock(clock),
    .we   (wr_acc & ~rst),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(ram_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign rd_data  = ram_rdata;
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clock) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= ram_rdata;
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: a default standard-mode FIFO and a small FWFT FIFO driven by directed vectors.
module tb_sync_fifo_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Standard-mode instance (defaults: 8 x 32, AF 28, AE 4)
  logic       rst, wr, rd, clr_err;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [5:0] count;

  // FWFT instance (16 x 8, AF 6, AE 2)
  logic        f_rst, f_wr, f_rd, f_clr_err;
  logic [15:0] f_wr_data, f_rd_data;
  logic        f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [3:0]  f_count;

  sync_fifo_param dut (
    .clock       (clock),
    .rst         (rst),
    .wr          (wr),
    .wr_data     (wr_data),
    .rd          (rd),
    .clr_err     (clr_err),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  sync_fifo_param #(
    .DATA_W  (16),
    .DEPTH   (8),
    .AF_LEVEL(6),
    .AE_LEVEL(2),
    .FWFT    (1)
  ) dut_fwft (
    .clock       (clock),
    .rst         (f_rst),
    .wr          (f_wr),
    .wr_data     (f_wr_data),
    .rd          (f_rd),
    .clr_err     (f_clr_err),
    .rd_data     (f_rd_data),
    .rd_valid    (f_rd_valid),
    .full        (f_full),
    .empty       (f_empty),
    .almost_full (f_almost_full),
    .almost_empty(f_almost_empty),
    .count       (f_count),
    .overflow    (f_overflow),
    .underflow   (f_underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic mon_en   = 1'b0;
  logic f_mon_en = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  model_q[$];
  logic [15:0] f_model[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Standard-mode monitor: every rd_valid pulse must match the oldest expected word,
  // arriving exactly one cycle after its read request.
  always @(negedge clock) begin
    if (mon_en && !rst) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rd_valid", 32'(rd_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e.data));
          check("rd_latency", cyc, e.due);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        check("missing_rd_valid", 32'(rd_valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  // FWFT monitor: the head word must always be presented while data is stored.
  always @(negedge clock) begin
    if (f_mon_en && !f_rst) begin
      check("fwft_rd_valid", 32'(f_rd_valid), 32'(f_model.size() != 0));
      if (f_rd_valid && f_model.size() != 0) begin
        check("fwft_head", 32'(f_rd_data), 32'(f_model[0]));
      end
    end
  end

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic r_acc, w_acc;
    wr = w; wr_data = d; rd = r; clr_err = c;
    r_acc = r && (model_q.size() != 0);
    w_acc = w && ((model_q.size() < 32) || r_acc);
    if (r_acc) exp_q.push_back('{data: model_q.pop_front(), due: cyc + 1});
    if (w_acc) model_q.push_back(d);
    @(posedge clock);
    #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic f_step(input logic w, input logic [15:0] d, input logic r);
    logic r_acc, w_acc;
    f_wr = w; f_wr_data = d; f_rd = r;
    r_acc = r && (f_model.size() != 0);
    w_acc = w && ((f_model.size() < 8) || r_acc);
    @(posedge clock);
    #1;
    if (r_acc) void'(f_model.pop_front());
    if (w_acc) f_model.push_back(d);
    f_wr = 1'b0; f_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int written;
    int iter;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; wr_data = '0;
    f_rst = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_clr_err = 1'b0; f_wr_data = '0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0; f_rst = 1'b0;

    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_almost_empty", 32'(almost_empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_almost_full", 32'(almost_full), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);
    mon_en = 1'b1;

    // Fill with 0x01..0x20
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      check("fill_count", 32'(count), i);
      check("fill_almost_full", 32'(almost_full), 32'(i >= 28));
      check("fill_almost_empty", 32'(almost_empty), 32'(i <= 4));
      check("fill_full", 32'(full), 32'(i == 32));
    end
    step(1'b1, 8'h99, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(count), 32);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 0);

    // Drain; the monitor checks 0x01..0x20 in order at latency 1
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_count", 32'(count), 31 - i);
      check("drain_almost_empty", 32'(almost_empty), 32'((31 - i) <= 4));
    end
    check("drain_empty", 32'(empty), 1);

    // Read while empty
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_set", 32'(underflow), 1);
    check("unf_rd_valid", 32'(rd_valid), 0);
    check("unf_count", 32'(count), 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("unf_clr", 32'(underflow), 0);

    // Simultaneous rd+wr at empty: read rejected, write accepted
    step(1'b1, 8'h60, 1'b1, 1'b0);
    check("rw_empty_underflow", 32'(underflow), 1);
    check("rw_empty_count", 32'(count), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("rw_empty_drain", 32'(count), 0);

    // Simultaneous rd+wr at count 10
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    check("rw10_pre", 32'(count), 10);
    step(1'b1, 8'h50, 1'b1, 1'b0);
    check("rw10_count", 32'(count), 10);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("rw10_drain", 32'(count), 0);

    // Simultaneous rd+wr at full
    for (int i = 0; i < 32; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("rwfull_overflow", 32'(overflow), 0);
    check("rwfull_count", 32'(count), 32);
    check("rwfull_full", 32'(full), 1);
    for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("rwfull_drain", 32'(count), 0);

    // Wrap-around stream, occupancy kept within 1..31
    written = 1;
    step(1'b1, 8'hA0, 1'b0, 1'b0);
    iter = 0;
    while (written < 100 && iter < 2000) begin
      logic w, r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (model_q.size() <= 1) r = 1'b0;
      if (model_q.size() >= 31) w = 1'b0;
      step(w, 8'(8'hA0 + written), r, 1'b0);
      if (w) written++;
      check("wrap_count", 32'(count), 32'(model_q.size()));
      iter++;
    end
    check("wrap_written", written, 100);
    while (model_q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    check("wrap_end_empty", 32'(empty), 1);

    // FWFT instance
    f_mon_en = 1'b1;
    check("f_rst_rd_valid", 32'(f_rd_valid), 0);
    check("f_rst_empty", 32'(f_empty), 1);
    f_step(1'b1, 16'hAAAA, 1'b0);
    check("f_fwft_valid", 32'(f_rd_valid), 1);
    check("f_fwft_data", 32'(f_rd_data), 32'hAAAA);
    f_step(1'b0, 16'h0000, 1'b1);
    check("f_pop_valid", 32'(f_rd_valid), 0);
    check("f_pop_empty", 32'(f_empty), 1);
    check("f_no_errors", 32'({f_overflow, f_underflow}), 0);
    for (int i = 0; i < 5; i++) f_step(1'b1, 16'(16'h1000 + i), 1'b0);
    check("f_count5", 32'(f_count), 5);
    check("f_flags5", 32'({f_full, f_almost_full, f_almost_empty}), 0);
    f_step(1'b0, 16'h0000, 1'b1);
    check("f_next_head", 32'(f_rd_data), 32'h1001);
    f_step(1'b1, 16'h1005, 1'b0);
    check("f_count5b", 32'(f_count), 5);
    // Reset mid-stream with a concurrent write; reset wins
    f_rst = 1'b1; f_wr = 1'b1; f_wr_data = 16'hBEEF;
    @(posedge clock);
    #1;
    f_rst = 1'b0; f_wr = 1'b0;
    f_model.delete();
    check("f_midrst_count", 32'(f_count), 0);
    check("f_midrst_empty", 32'(f_empty), 1);
    check("f_midrst_valid", 32'(f_rd_valid), 0);
    f_step(1'b1, 16'h1234, 1'b0);
    f_step(1'b1, 16'h5678, 1'b0);
    f_step(1'b0, 16'h0000, 1'b1);
    check("f_after_rst_head", 32'(f_rd_data), 32'h5678);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
